// File: rtl/clock_set_ctrl.sv
// Seconds/minutes timekeeper with a 1 Hz prescaler.
// A mode button cycles RUN -> SET_MIN -> SET_SEC; an inc button sets the selected field.
module clock_set_ctrl #(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [5:0] seconds,
    output logic [5:0] minutes,
    output logic [1:0] mode,
    output logic       blink,
    output logic       sec_tick,
    output logic       hour_pulse
);
    localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] RUN_MAX   = PW'(TICKS_PER_SEC - 1);
    localparam logic [PW-1:0] BLINK_MAX = PW'(TICKS_PER_SEC / 2 - 1);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_MIN = 2'b01,
        SET_SEC = 2'b10,
        BAD     = 2'b11
    } state_t;

    state_t        state, state_nx;
    logic [PW-1:0] presc;
    logic          mode_prev, inc_prev;
    logic          mode_press, inc_press;

    // A mode press in the same cycle swallows any inc press.
    assign mode_press = mode_btn & ~mode_prev;
    assign inc_press  = inc_btn & ~inc_prev & ~mode_press;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            RUN:     if (mode_press) state_nx = SET_MIN;
            SET_MIN: if (mode_press) state_nx = SET_SEC;
            SET_SEC: if (mode_press) state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    always_comb begin
        mode = state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc      <= '0;
            seconds    <= '0;
            minutes    <= '0;
            blink      <= 1'b0;
            sec_tick   <= 1'b0;
            hour_pulse <= 1'b0;
            mode_prev  <= 1'b0;
            inc_prev   <= 1'b0;
        end else begin
            mode_prev  <= mode_btn;
            inc_prev   <= inc_btn;
            sec_tick   <= 1'b0;
            hour_pulse <= 1'b0;
            if (state_nx != state) begin
                // Every transition restarts the prescaler; blink starts lit in set states.
                presc <= '0;
                blink <= (state_nx != RUN);
            end else if (state == RUN) begin
                blink <= 1'b0;
                if (presc == RUN_MAX) begin
                    presc    <= '0;
                    sec_tick <= 1'b1;
                    if (seconds >= 6'd59) begin
                        seconds <= '0;
                        if (minutes >= 6'd59) begin
                            minutes    <= '0;
                            hour_pulse <= 1'b1;
                        end else begin
                            minutes <= minutes + 6'd1;
                        end
                    end else begin
                        seconds <= seconds + 6'd1;
                    end
                end else begin
                    presc <= presc + PW'(1);
                end
            end else begin
                // Half-second prescaler drives a 1 Hz blink square wave.
                if (presc == BLINK_MAX) begin
                    presc <= '0;
                    blink <= ~blink;
                end else begin
                    presc <= presc + PW'(1);
                end
                if (inc_press) begin
                    if (state == SET_MIN)
                        minutes <= (minutes >= 6'd59) ? 6'd0 : minutes + 6'd1;
                    else
                        seconds <= (seconds >= 6'd59) ? 6'd0 : seconds + 6'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_clock_set_ctrl.sv
// Randomized and directed bench for clock_set_ctrl against a total-seconds reference model.
module tb_clock_set_ctrl;
    localparam int T = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mode_btn = 1'b0;
    logic       inc_btn = 1'b0;
    logic [5:0] seconds, minutes;
    logic [1:0] mode;
    logic       blink, sec_tick, hour_pulse;

    clock_set_ctrl #(.TICKS_PER_SEC(T)) dut (
        .clk(clk), .reset(reset), .mode_btn(mode_btn), .inc_btn(inc_btn),
        .seconds(seconds), .minutes(minutes), .mode(mode), .blink(blink),
        .sec_tick(sec_tick), .hour_pulse(hour_pulse)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: time as total seconds, mode as 0/1/2, cycles elapsed since last mode entry.
    int m_mode, m_total, m_cnt;
    bit m_tick, m_hour, m_pm, m_pi;

    wire [16:0] dut_vec = {seconds, minutes, mode, blink, sec_tick, hour_pulse};

    function automatic logic [16:0] exp_vec();
        logic b;
        b = (m_mode != 0) && (((m_cnt / (T / 2)) % 2) == 0);
        return {6'(m_total % 60), 6'(m_total / 60), 2'(m_mode), b, m_tick, m_hour};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_total = 0; m_cnt = 0;
        m_tick = 0; m_hour = 0; m_pm = 0; m_pi = 0;
    endtask

    // Drive one cycle of inputs, advance the model at the edge, return just after it.
    task automatic step(input logic mb, input logic ib);
        bit mp, ip;
        @(negedge clk);
        mode_btn = mb;
        inc_btn  = ib;
        @(posedge clk);
        mp = mb && !m_pm;
        ip = ib && !m_pi && !mp;
        m_pm = mb; m_pi = ib;
        m_tick = 0; m_hour = 0;
        if (mp) begin
            m_mode = (m_mode + 1) % 3;
            m_cnt  = 0;
        end else begin
            m_cnt++;
            case (m_mode)
                0: if (m_cnt % T == 0) begin
                       m_total = (m_total + 1) % 3600;
                       m_tick  = 1;
                       m_hour  = (m_total == 0);
                   end
                1: if (ip) m_total = ((m_total / 60 + 1) % 60) * 60 + m_total % 60;
                default: if (ip) m_total = (m_total / 60) * 60 + (m_total % 60 + 1) % 60;
            endcase
        end
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        mode_btn = 1'b0;
        inc_btn = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if (dut_vec !== 17'd0) begin
            errors++;
            $display("FAIL reset_state got %h want %h", dut_vec, 17'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_run();
        int ticks = 0;
        for (int i = 0; i < 240; i++) begin
            step(1'b0, 1'b0);
            ticks += sec_tick;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL run cyc%0d got %h want %h", i, dut_vec, exp_vec());
            end
            if (i == 3) begin
                checks++;
                if (seconds !== 6'd1) begin
                    errors++;
                    $display("FAIL run_first_sec got %0d want 1", seconds);
                end
            end
        end
        checks++;
        if (minutes !== 6'd1 || seconds !== 6'd0 || ticks != 60) begin
            errors++;
            $display("FAIL run_240 got %0d:%0d ticks %0d want 1:0 ticks 60", minutes, seconds, ticks);
        end
    endtask

    task automatic test_set_time();
        logic [1:0] q[$];
        apply_reset();
        q.push_back(2'b10); q.push_back(2'b00);
        for (int i = 0; i < 3; i++) begin q.push_back(2'b01); q.push_back(2'b00); end
        q.push_back(2'b10); q.push_back(2'b00);
        for (int i = 0; i < 2; i++) begin q.push_back(2'b01); q.push_back(2'b00); end
        q.push_back(2'b10); q.push_back(2'b00);
        foreach (q[i]) begin
            step(q[i][1], q[i][0]);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL set_time step%0d got %h want %h", i, dut_vec, exp_vec());
            end
        end
        checks++;
        if (minutes !== 6'd3 || seconds !== 6'd2 || mode !== 2'b00 || blink !== 1'b0) begin
            errors++;
            $display("FAIL set_time_result got %0d:%0d mode %0d blink %b want 3:2 mode 0 blink 0",
                     minutes, seconds, mode, blink);
        end
    endtask

    task automatic test_rollover();
        logic [1:0] q[$];
        apply_reset();
        q.push_back(2'b10); q.push_back(2'b00);
        for (int i = 0; i < 59; i++) begin q.push_back(2'b01); q.push_back(2'b00); end
        q.push_back(2'b10); q.push_back(2'b00);
        for (int i = 0; i < 59; i++) begin q.push_back(2'b01); q.push_back(2'b00); end
        q.push_back(2'b10);
        for (int i = 0; i < T; i++) q.push_back(2'b00);
        foreach (q[i]) begin
            step(q[i][1], q[i][0]);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL rollover step%0d got %h want %h", i, dut_vec, exp_vec());
            end
        end
        checks++;
        if (seconds !== 6'd0 || minutes !== 6'd0 || hour_pulse !== 1'b1 || sec_tick !== 1'b1) begin
            errors++;
            $display("FAIL rollover_hour got %0d:%0d hp %b st %b want 0:0 hp 1 st 1",
                     minutes, seconds, hour_pulse, sec_tick);
        end
    endtask

    task automatic test_wrap_set();
        logic [1:0] q[$];
        apply_reset();
        q.push_back(2'b10); q.push_back(2'b00); q.push_back(2'b01); q.push_back(2'b00);
        q.push_back(2'b10); q.push_back(2'b00);
        for (int i = 0; i < 60; i++) begin q.push_back(2'b01); q.push_back(2'b00); end
        foreach (q[i]) begin
            step(q[i][1], q[i][0]);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL wrap_set step%0d got %h want %h", i, dut_vec, exp_vec());
            end
        end
        checks++;
        if (seconds !== 6'd0 || minutes !== 6'd1 || mode !== 2'b10) begin
            errors++;
            $display("FAIL wrap_set_result got %0d:%0d mode %0d want 1:0 mode 2", minutes, seconds, mode);
        end
    endtask

    task automatic test_simultaneous();
        logic [1:0] q[$];
        apply_reset();
        q.push_back(2'b10); q.push_back(2'b00); q.push_back(2'b01); q.push_back(2'b00);
        q.push_back(2'b11); q.push_back(2'b00);
        for (int i = 0; i < 10; i++) q.push_back(2'b01);
        q.push_back(2'b00);
        foreach (q[i]) begin
            step(q[i][1], q[i][0]);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL simul step%0d got %h want %h", i, dut_vec, exp_vec());
            end
            if (i == 4) begin
                checks++;
                if (mode !== 2'b10 || minutes !== 6'd1) begin
                    errors++;
                    $display("FAIL simul_mode_wins got mode %0d min %0d want mode 2 min 1", mode, minutes);
                end
            end
        end
        checks++;
        if (seconds !== 6'd1) begin
            errors++;
            $display("FAIL held_inc got %0d want 1", seconds);
        end
    endtask

    task automatic test_async_reset();
        logic [1:0] q[$];
        apply_reset();
        q.push_back(2'b10); q.push_back(2'b00);
        for (int i = 0; i < 12; i++) begin q.push_back(2'b01); q.push_back(2'b00); end
        q.push_back(2'b10); q.push_back(2'b00);
        for (int i = 0; i < 34; i++) begin q.push_back(2'b01); q.push_back(2'b00); end
        foreach (q[i]) step(q[i][1], q[i][0]);
        checks++;
        if (minutes !== 6'd12 || seconds !== 6'd34 || mode !== 2'b10) begin
            errors++;
            $display("FAIL async_preload got %0d:%0d mode %0d want 12:34 mode 2", minutes, seconds, mode);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (dut_vec !== 17'd0) begin
            errors++;
            $display("FAIL async_reset got %h want %h", dut_vec, 17'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < T + 2; i++) begin
            step(1'b0, 1'b0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL async_restart cyc%0d got %h want %h", i, dut_vec, exp_vec());
            end
        end
        // A mode button already high as reset releases counts as a press.
        reset = 1'b1;
        mode_btn = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        step(1'b1, 1'b0);
        checks++;
        if (mode !== 2'b01 || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL held_at_reset got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        logic mb, ib;
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            mb = ($urandom % 10) == 0;
            ib = ($urandom % 3) == 0;
            step(mb, ib);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc%0d got %h want %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_run();
        test_set_time();
        test_rollover();
        test_wrap_set();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
